// File: rtl/cond_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// cond_sequencer
//
// Issue-stage controller for conditional execution. Owns the architectural
// NZCV flag register, evaluates each presented instruction's 4-bit condition
// field against it, gates register/memory/PC writes, and sequences flag
// updates from the single-cycle ALU and from a multi-cycle flag-setting unit
// (e.g. multiply). While a multi-cycle flag update is pending, only AL
// non-flag-setting instructions may issue; everything else is held off via
// the valid/ready handshake so no instruction ever reads stale flags.
//
// Parameters
//   MUL_LAT       cycles from multi-cycle issue to valid mc_flags (1..15)
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   in_valid      decode presents an instruction
//   in_ready      sequencer accepts it this cycle
//   cond[3:0]     condition field (EQ=0000 .. AL=1110, 1111 undefined)
//   flag_w[1:0]   [1] update N,Z ; [0] update C,V
//   multi         instruction is a multi-cycle flag-setting op
//   alu_flags     NZCV from the single-cycle ALU, same cycle as issue
//   mc_flags      NZCV from the multi-cycle unit
//   reg_w_in, mem_w_in, pcs_in   ungated decode write controls
//   reg_w, mem_w, pcs            gated write controls
//   issue         handshake completed (in_valid & in_ready)
//   cond_ex       condition passed for the presented instruction
//   undef         presented cond == 1111
//   flags[3:0]    current NZCV register {N,Z,C,V}
//
// Optional feature (macro COND_SEQ_PERF_EN):
//   stall_cycles[15:0]  cycles with in_valid & ~in_ready (saturating)
//   skip_cnt[15:0]      issues whose condition failed (saturating)
// -----------------------------------------------------------------------------
module cond_sequencer #(
   parameter int MUL_LAT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] cond,
   input  logic [1:0] flag_w,
   input  logic       multi,
   input  logic [3:0] alu_flags,
   input  logic [3:0] mc_flags,
   input  logic       reg_w_in,
   input  logic       mem_w_in,
   input  logic       pcs_in,
   output logic       reg_w,
   output logic       mem_w,
   output logic       pcs,
   output logic       issue,
   output logic       cond_ex,
   output logic       undef,
   output logic [3:0] flags
`ifdef COND_SEQ_PERF_EN
   ,
   output logic [15:0] stall_cycles,
   output logic [15:0] skip_cnt
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [3:0] LAT_INIT = 4'(MUL_LAT);
   localparam logic [3:0] COND_AL  = 4'b1110;
   localparam logic [3:0] COND_NV  = 4'b1111;

   state_t     state, state_next;
   logic [3:0] cnt, cnt_next;
   logic [3:0] flags_next;
   logic [1:0] fw_lat, fw_lat_next;   // flag_w of the pending multi-cycle op
   logic       cond_pass;

   // Replace the selected halves of the NZCV register: sel[1] covers N,Z,
   // sel[0] covers C,V.
   function automatic logic [3:0] merge_flags(input logic [3:0] cur,
                                              input logic [3:0] upd,
                                              input logic [1:0] sel);
      merge_flags = {sel[1] ? upd[3:2] : cur[3:2],
                     sel[0] ? upd[1:0] : cur[1:0]};
   endfunction

   // Condition evaluation against the architectural flags only; mc_flags is
   // deliberately never bypassed here.
   always_comb begin
      // NOTE: every combinational output gets a default before the case so no
      // path leaves it unassigned (which would infer a latch).
      cond_pass = 1'b0;
      case (cond)
         4'b0000: cond_pass =  flags[2];                        // EQ
         4'b0001: cond_pass = ~flags[2];                        // NE
         4'b0010: cond_pass =  flags[1];                        // CS
         4'b0011: cond_pass = ~flags[1];                        // CC
         4'b0100: cond_pass =  flags[3];                        // MI
         4'b0101: cond_pass = ~flags[3];                        // PL
         4'b0110: cond_pass =  flags[0];                        // VS
         4'b0111: cond_pass = ~flags[0];                        // VC
         4'b1000: cond_pass = ~flags[2] &  flags[1];            // HI
         4'b1001: cond_pass =  flags[2] | ~flags[1];            // LS
         4'b1010: cond_pass = ~(flags[3] ^ flags[0]);           // GE
         4'b1011: cond_pass =  (flags[3] ^ flags[0]);           // LT
         4'b1100: cond_pass = ~flags[2] & ~(flags[3] ^ flags[0]); // GT
         4'b1101: cond_pass =  flags[2] |  (flags[3] ^ flags[0]); // LE
         4'b1110: cond_pass = 1'b1;                             // AL
         default: cond_pass = 1'b0;                             // 1111 undefined
      endcase
   end

   // Next-state and output logic.
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      flags_next  = flags;
      fw_lat_next = fw_lat;
      in_ready    = 1'b1;

      // While BUSY only AL instructions that touch no flags may pass; this
      // depends on the presented fields, not on in_valid.
      if (state == BUSY) begin
         in_ready = (cond == COND_AL) && (flag_w == 2'b00) && !multi;
      end

      issue   = in_valid & in_ready;
      cond_ex = in_valid & cond_pass;
      undef   = (cond == COND_NV);
      reg_w   = reg_w_in & cond_ex & issue;
      mem_w   = mem_w_in & cond_ex & issue;
      pcs     = pcs_in   & cond_ex & issue;

      case (state)
         IDLE: begin
            if (issue && cond_pass && (flag_w != 2'b00)) begin
               if (multi) begin
                  state_next  = BUSY;
                  cnt_next    = LAT_INIT;
                  fw_lat_next = flag_w;
               end else begin
                  flags_next = merge_flags(flags, alu_flags, flag_w);
               end
            end
         end
         BUSY: begin
            // The count runs regardless of in_valid; any instruction that
            // issues here is AL with flag_w==0 and cannot touch the flags.
            cnt_next = cnt - 4'd1;
            if (cnt == 4'd1) begin
               flags_next = merge_flags(flags, mc_flags, fw_lat);
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      if (reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         flags  <= 4'b0000;
         fw_lat <= 2'b00;
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         flags  <= flags_next;
         fw_lat <= fw_lat_next;
      end
   end

`ifdef COND_SEQ_PERF_EN
   // Saturating event counters for performance analysis.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cycles <= 16'd0;
         skip_cnt     <= 16'd0;
      end else begin
         if (in_valid && !in_ready && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
         end
         if (issue && !cond_pass && (skip_cnt != 16'hFFFF)) begin
            skip_cnt <= skip_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_cond_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_cond_sequencer
//
// Self-checking bench for cond_sequencer (MUL_LAT=3). A reference model of
// the flag register and BUSY window produces the expected outputs for every
// driven cycle; those are queued when the stimulus is applied and compared
// against the DUT at the following falling edge. Directed sequences cover the
// single-cycle, partial, multi-cycle, AL-during-BUSY, reset-during-BUSY and
// undefined-condition cases, followed by a random phase.
// -----------------------------------------------------------------------------
module tb_cond_sequencer;

   localparam int MUL_LAT = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] cond;
   logic [1:0] flag_w;
   logic       multi;
   logic [3:0] alu_flags;
   logic [3:0] mc_flags;
   logic       reg_w_in, mem_w_in, pcs_in;
   logic       reg_w, mem_w, pcs;
   logic       issue, cond_ex, undef;
   logic [3:0] flags;
`ifdef COND_SEQ_PERF_EN
   logic [15:0] stall_cycles, skip_cnt;
`endif

   always #5 clk = ~clk;

   cond_sequencer #(.MUL_LAT(MUL_LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cond      (cond),
      .flag_w    (flag_w),
      .multi     (multi),
      .alu_flags (alu_flags),
      .mc_flags  (mc_flags),
      .reg_w_in  (reg_w_in),
      .mem_w_in  (mem_w_in),
      .pcs_in    (pcs_in),
      .reg_w     (reg_w),
      .mem_w     (mem_w),
      .pcs       (pcs),
      .issue     (issue),
      .cond_ex   (cond_ex),
      .undef     (undef),
      .flags     (flags)
`ifdef COND_SEQ_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .skip_cnt     (skip_cnt)
`endif
   );

   typedef struct {
      logic       rst;
      logic       valid;
      logic [3:0] cond;
      logic [1:0] fw;
      logic       multi;
      logic [3:0] alu;
      logic [3:0] mc;
      logic       rw, mw, pc;
   } stim_t;

   typedef struct {
      logic       in_ready, issue, cond_ex, undef, reg_w, mem_w, pcs;
      logic [3:0] flags;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [3:0] m_flags = 4'b0000;
   bit         m_busy  = 1'b0;
   int         m_cnt   = 0;
   logic [1:0] m_fw    = 2'b00;
   int         m_stall = 0;
   int         m_skip  = 0;

   localparam logic [3:0] EQ = 4'h0, NE = 4'h1, GE = 4'hA, AL = 4'hE, NV = 4'hF;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", tag, $time, got, exp);
      end
   endtask

   // Condition evaluation written from the ARM pairing rule: odd codes
   // invert the even code's base test.
   function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, base;
      {n, z, cf, v} = f;
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cf;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cf & ~z;
         3'd5:    base = (n == v);
         3'd6:    base = ~z & (n == v);
         default: base = 1'b1;
      endcase
      if (c == AL) return 1'b1;
      if (c == NV) return 1'b0;
      return c[0] ? ~base : base;
   endfunction

   function automatic logic [3:0] ref_merge(input logic [3:0] cur, input logic [3:0] upd,
                                            input logic [1:0] fw);
      logic [3:0] mask;
      mask = {{2{fw[1]}}, {2{fw[0]}}};
      return (cur & ~mask) | (upd & mask);
   endfunction

   function automatic stim_t mk(input logic v, input logic [3:0] c,
                                input logic [1:0] fw = 2'b00, input logic m = 1'b0,
                                input logic [3:0] alu = 4'h0, input logic [3:0] mc = 4'h0,
                                input logic rw = 1'b0, input logic mw = 1'b0,
                                input logic pc = 1'b0, input logic rst = 1'b0);
      stim_t s;
      s.rst = rst; s.valid = v; s.cond = c; s.fw = fw; s.multi = m;
      s.alu = alu; s.mc = mc; s.rw = rw; s.mw = mw; s.pc = pc;
      return s;
   endfunction

   // One clock cycle: drive, queue the model's expectation, compare at the
   // falling edge, then advance the model across the next rising edge.
   task automatic run(input stim_t s);
      exp_t e, got;
      logic rdy, iss, pass;
      @(posedge clk);
      #1;
      reset     = s.rst;
      in_valid  = s.valid;
      cond      = s.cond;
      flag_w    = s.fw;
      multi     = s.multi;
      alu_flags = s.alu;
      mc_flags  = s.mc;
      reg_w_in  = s.rw;
      mem_w_in  = s.mw;
      pcs_in    = s.pc;

      rdy  = !m_busy || (s.cond == AL && s.fw == 2'b00 && !s.multi);
      iss  = s.valid & rdy;
      pass = ref_pass(s.cond, m_flags);
      e.in_ready = rdy;
      e.issue    = iss;
      e.cond_ex  = s.valid & pass;
      e.undef    = (s.cond == NV);
      e.reg_w    = s.rw & s.valid & pass & iss;
      e.mem_w    = s.mw & s.valid & pass & iss;
      e.pcs      = s.pc & s.valid & pass & iss;
      e.flags    = m_flags;
      exp_q.push_back(e);

      @(negedge clk);
      got = exp_q.pop_front();
      check("in_ready", 16'(in_ready), 16'(got.in_ready));
      check("issue",    16'(issue),    16'(got.issue));
      check("cond_ex",  16'(cond_ex),  16'(got.cond_ex));
      check("undef",    16'(undef),    16'(got.undef));
      check("reg_w",    16'(reg_w),    16'(got.reg_w));
      check("mem_w",    16'(mem_w),    16'(got.mem_w));
      check("pcs",      16'(pcs),      16'(got.pcs));
      check("flags",    16'(flags),    16'(got.flags));
`ifdef COND_SEQ_PERF_EN
      check("stall_cycles", stall_cycles, 16'(m_stall));
      check("skip_cnt",     skip_cnt,     16'(m_skip));
`endif

      if (s.rst) begin
         m_flags = 4'b0000;
         m_busy  = 1'b0;
         m_cnt   = 0;
         m_stall = 0;
         m_skip  = 0;
      end else begin
         if (s.valid && !rdy && m_stall < 16'hFFFF) m_stall++;
         if (iss && !pass && m_skip < 16'hFFFF) m_skip++;
         if (!m_busy) begin
            if (iss && pass && s.fw != 2'b00) begin
               if (s.multi) begin
                  m_busy = 1'b1;
                  m_cnt  = MUL_LAT;
                  m_fw   = s.fw;
               end else begin
                  m_flags = ref_merge(m_flags, s.alu, s.fw);
               end
            end
         end else begin
            if (m_cnt == 1) begin
               m_flags = ref_merge(m_flags, s.mc, m_fw);
               m_busy  = 1'b0;
            end
            m_cnt--;
         end
      end
   endtask

   initial begin
      stim_t s;
      reset = 1'b1; in_valid = 1'b0; cond = 4'h0; flag_w = 2'b00; multi = 1'b0;
      alu_flags = 4'h0; mc_flags = 4'h0; reg_w_in = 1'b0; mem_w_in = 1'b0; pcs_in = 1'b0;
      repeat (2) @(posedge clk);

      // Reset values, undef follows cond even with in_valid low
      run(mk(1'b0, NV));
      check("rst_flags", 16'(flags), 16'h0);
      check("rst_ready", 16'(in_ready), 16'h1);
      check("rst_undef", 16'(undef), 16'h1);

      // Single-cycle flag write, then dependent EQ back-to-back
      run(mk(1'b1, AL, 2'b11, 1'b0, 4'b0100));
      run(mk(1'b1, EQ, 2'b00, 1'b0, 4'h0, 4'h0, 1'b1));
      check("eq_flags", 16'(flags), 16'b0100);
      check("eq_cond_ex", 16'(cond_ex), 16'h1);
      check("eq_reg_w", 16'(reg_w), 16'h1);
      run(mk(1'b1, NE, 2'b00, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1));
      check("ne_cond_ex", 16'(cond_ex), 16'h0);
      check("ne_mem_w", 16'(mem_w), 16'h0);
      check("ne_flags", 16'(flags), 16'b0100);

      // Partial update: 1111 with C,V written to 0 gives 1100
      run(mk(1'b1, AL, 2'b11, 1'b0, 4'b1111));
      run(mk(1'b1, AL, 2'b01, 1'b0, 4'b0000));
      run(mk(1'b0, EQ));
      check("partial_flags", 16'(flags), 16'b1100);

      // Multi-cycle op; GE presented t+1..t+3 stalls, issues at t+4
      run(mk(1'b1, AL, 2'b11, 1'b1, 4'h0, 4'b1000));
      for (int k = 1; k <= MUL_LAT; k++) begin
         run(mk(1'b1, GE, 2'b00, 1'b0, 4'h0, 4'b1000));
         check("ge_stall", 16'(in_ready), 16'h0);
      end
      run(mk(1'b1, GE, 2'b00, 1'b0, 4'h0, 4'b1000));
      check("ge_ready", 16'(in_ready), 16'h1);
      check("ge_issue", 16'(issue), 16'h1);
      check("mc_flags", 16'(flags), 16'b1000);
      check("ge_cond_ex", 16'(cond_ex), 16'h0);

      // AL during BUSY issues; BUSY count unaffected
      run(mk(1'b1, AL, 2'b11, 1'b1, 4'h0, 4'b0010));
      run(mk(1'b1, AL, 2'b00, 1'b0, 4'h0, 4'b0010, 1'b0, 1'b0, 1'b1));
      check("al_busy_ready", 16'(in_ready), 16'h1);
      check("al_busy_pcs", 16'(pcs), 16'h1);
      run(mk(1'b0, EQ, 2'b00, 1'b0, 4'h0, 4'b0010));
      run(mk(1'b0, EQ, 2'b00, 1'b0, 4'h0, 4'b0010));
      run(mk(1'b1, EQ));
      check("al_busy_flags", 16'(flags), 16'b0010);

      // Reset at t+2 of BUSY discards the pending update
      run(mk(1'b1, AL, 2'b11, 1'b1, 4'h0, 4'b0111));
      run(mk(1'b0, EQ, 2'b00, 1'b0, 4'h0, 4'b0111));
      run(mk(1'b0, EQ, 2'b00, 1'b0, 4'h0, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b1));
      run(mk(1'b1, GE, 2'b00, 1'b0, 4'h0, 4'b0111));
      check("rstbusy_flags", 16'(flags), 16'h0);
      check("rstbusy_ready", 16'(in_ready), 16'h1);
      run(mk(1'b0, EQ, 2'b00, 1'b0, 4'h0, 4'b0111));
      run(mk(1'b0, EQ, 2'b00, 1'b0, 4'h0, 4'b0111));
      check("rstbusy_ignored", 16'(flags), 16'h0);

      // Undefined condition: never executes, never writes flags
      run(mk(1'b1, NV, 2'b11, 1'b0, 4'b1111, 4'h0, 1'b1, 1'b1, 1'b1));
      check("nv_undef", 16'(undef), 16'h1);
      check("nv_cond_ex", 16'(cond_ex), 16'h0);
      run(mk(1'b0, EQ));
      check("nv_flags", 16'(flags), 16'h0);

      // Random phase, model-checked every cycle
      for (int i = 0; i < 400; i++) begin
         s = mk(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
                4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 80) == 0));
         if (m_busy && $urandom_range(0, 1) == 1) begin
            s.cond = AL; s.fw = 2'b00; s.multi = 1'b0;
         end
         run(s);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
